// File: rtl/slv_pkg.sv
// Shared AXI4 types and defaults for the monitor's internal-ID (downstream) side.
package slv_pkg;

  localparam int unsigned AxiIntIdWidth = 4;
  localparam int unsigned AxiAddrWidth  = 32;
  localparam int unsigned AxiDataWidth  = 64;
  localparam int unsigned AxiUserWidth  = 1;
  localparam int unsigned CntWidth      = 10;

  localparam logic [1:0]  ErrResp     = 2'b10;
  localparam logic [63:0] ErrRespData = 64'hBADC_AB1E_DEAD_BEEF;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DRAIN,
    W_RESP,
    W_ATOP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } r_state_e;

  typedef struct packed {
    logic [AxiIntIdWidth-1:0] id;
    logic [AxiAddrWidth-1:0]  addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic [5:0]               atop;
    logic [AxiUserWidth-1:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIntIdWidth-1:0] id;
    logic [1:0]               resp;
    logic [AxiUserWidth-1:0]  user;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIntIdWidth-1:0] id;
    logic [AxiAddrWidth-1:0]  addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic [AxiUserWidth-1:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIntIdWidth-1:0] id;
    logic [AxiDataWidth-1:0]  data;
    logic [1:0]               resp;
    logic                     last;
    logic [AxiUserWidth-1:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } slv_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } slv_resp_t;

endpackage

// File: rtl/axi_err_slv.sv
// AXI4 error responder: completes every write with one error B and every read with len+1 error R beats.
// Atomic writes (atop[5]) are also answered on R, handed from the write FSM to the read FSM.
module axi_err_slv #(
  parameter type         axi_req_t  = slv_pkg::slv_req_t,
  parameter type         axi_resp_t = slv_pkg::slv_resp_t,
  parameter logic [63:0] RespData   = slv_pkg::ErrRespData,
  parameter logic [1:0]  Resp       = slv_pkg::ErrResp,
  parameter int unsigned CntWidth   = slv_pkg::CntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_req_t            req_i,
  output axi_resp_t           rsp_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] err_cnt_o
);
  import slv_pkg::*;

  w_state_e                 w_state_q;
  r_state_e                 r_state_q;
  logic [AxiIntIdWidth-1:0] aw_id_q, atop_id_q, r_id_q;
  logic [7:0]               aw_len_q, atop_len_q, r_len_q, beat_q;
  logic                     aw_atop_q, atop_sent_q, atop_pend_q;
  logic [CntWidth-1:0]      err_cnt_q;

  logic b_valid, r_valid, r_last, b_hs, r_last_hs, atop_set, atop_take;

  assign b_valid   = (w_state_q == W_RESP);
  assign r_valid   = (r_state_q == R_SEND);
  assign r_last    = r_valid && (beat_q == r_len_q);
  assign b_hs      = b_valid && req_i.b_ready;
  assign r_last_hs = r_last && req_i.r_ready;
  assign atop_set  = (w_state_q == W_ATOP) && !atop_sent_q;
  assign atop_take = (r_state_q == R_IDLE) && atop_pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q   <= W_IDLE;
      aw_id_q     <= '0;
      aw_len_q    <= '0;
      aw_atop_q   <= 1'b0;
      atop_sent_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (req_i.aw_valid) begin
          aw_id_q   <= req_i.aw.id;
          aw_len_q  <= req_i.aw.len;
          aw_atop_q <= req_i.aw.atop[5];
          w_state_q <= W_DRAIN;
        end
        W_DRAIN: if (req_i.w_valid && req_i.w.last) w_state_q <= W_RESP;
        W_RESP: if (req_i.b_ready) w_state_q <= aw_atop_q ? W_ATOP : W_IDLE;
        W_ATOP: begin
          // First cycle posts the hand-off; then wait for the read FSM to pick it up.
          if (!atop_sent_q) begin
            atop_sent_q <= 1'b1;
          end else if (!atop_pend_q) begin
            atop_sent_q <= 1'b0;
            w_state_q   <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      atop_pend_q <= 1'b0;
      atop_id_q   <= '0;
      atop_len_q  <= '0;
    end else if (atop_set) begin
      atop_pend_q <= 1'b1;
      atop_id_q   <= aw_id_q;
      atop_len_q  <= aw_len_q;
    end else if (atop_take) begin
      atop_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      beat_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          // A pending atomic wins over a new AR; ar_ready is low while it is pending.
          if (atop_pend_q) begin
            r_id_q    <= atop_id_q;
            r_len_q   <= atop_len_q;
            beat_q    <= '0;
            r_state_q <= R_SEND;
          end else if (req_i.ar_valid) begin
            r_id_q    <= req_i.ar.id;
            r_len_q   <= req_i.ar.len;
            beat_q    <= '0;
            r_state_q <= R_SEND;
          end
        end
        R_SEND: if (req_i.r_ready) begin
          if (r_last) r_state_q <= R_IDLE;
          else        beat_q    <= beat_q + 8'd1;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic [1:0]        cnt_inc;
  logic [CntWidth:0] cnt_sum;
  assign cnt_inc = {1'b0, b_hs} + {1'b0, r_last_hs};
  assign cnt_sum = {1'b0, err_cnt_q} + (CntWidth + 1)'(cnt_inc);

  always_ff @(posedge clk_i) begin
    if (rst_i)               err_cnt_q <= '0;
    else if (cnt_sum[CntWidth]) err_cnt_q <= '1;
    else                     err_cnt_q <= cnt_sum[CntWidth-1:0];
  end

  always_comb begin
    rsp_o          = '0;
    rsp_o.aw_ready = (w_state_q == W_IDLE);
    rsp_o.w_ready  = (w_state_q == W_DRAIN);
    rsp_o.b_valid  = b_valid;
    rsp_o.b.id     = aw_id_q;
    rsp_o.b.resp   = Resp;
    rsp_o.ar_ready = (r_state_q == R_IDLE) && !atop_pend_q;
    rsp_o.r_valid  = r_valid;
    rsp_o.r.id     = r_id_q;
    rsp_o.r.data   = AxiDataWidth'(RespData);
    rsp_o.r.resp   = Resp;
    rsp_o.r.last   = r_last;
  end

  assign busy_o    = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);
  assign err_cnt_o = err_cnt_q;

  logic unused_req;
  assign unused_req = ^req_i;

endmodule

// File: tb/tb_axi_err_slv.sv
// Directed bench for axi_err_slv: writes, reads, atomic hand-off, counter saturation and reset.
module tb_axi_err_slv;
  import slv_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  slv_req_t  req;
  slv_resp_t rsp;
  logic      busy;
  logic [9:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  axi_err_slv dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .rsp_o     (rsp),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input int nbeats);
    req.aw_valid = 1'b1; req.aw.id = id; req.aw.len = 8'(nbeats - 1); req.aw.atop = 6'd0;
    check_eq("aw_ready", rsp.aw_ready, 1);
    step();
    req.aw_valid = 1'b0;
    check_eq("w_ready_lat", rsp.w_ready, 1);
    check_eq("busy_w", busy, 1);
    for (int i = 0; i < nbeats; i++) begin
      req.w_valid = 1'b1; req.w.last = (i == nbeats - 1);
      check_eq("b_early", rsp.b_valid, 0);
      step();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    check_eq("b_valid", rsp.b_valid, 1);
    check_eq("b_id", rsp.b.id, id);
    check_eq("b_resp", rsp.b.resp, 2'b10);
    check_eq("b_user", rsp.b.user, 0);
    check_eq("w_ready_off", rsp.w_ready, 0);
    req.b_ready = 1'b1;
    step();
    req.b_ready = 1'b0;
    check_eq("b_done", rsp.b_valid, 0);
    check_eq("aw_ready_back", rsp.aw_ready, 1);
    $display("write id=%0d beats=%0d err_cnt=%0d", id, nbeats, err_cnt);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input bit toggle);
    int beats = 0;
    bit done = 0, stalled = 0, prev_last = 0;
    req.ar_valid = 1'b1; req.ar.id = id; req.ar.len = len;
    check_eq("ar_ready", rsp.ar_ready, 1);
    step();
    req.ar_valid = 1'b0;
    check_eq("r_lat", rsp.r_valid, 1);
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      req.r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        check_eq("r_hold_valid", rsp.r_valid, 1);
        check_eq("r_hold_last", rsp.r.last, prev_last);
      end
      if (rsp.r_valid) begin
        check_eq("r_data", rsp.r.data, 64'hBADC_AB1E_DEAD_BEEF);
        check_eq("r_id", rsp.r.id, id);
        check_eq("r_resp", rsp.r.resp, 2'b10);
        check_eq("r_last", rsp.r.last, (beats == int'(len)));
      end
      stalled   = rsp.r_valid && !req.r_ready;
      prev_last = rsp.r.last;
      if (rsp.r_valid && req.r_ready) begin
        beats++;
        if (rsp.r.last) done = 1;
      end
      step();
    end
    req.r_ready = 1'b0;
    check_eq("r_done", done, 1);
    check_eq("r_beats", beats, int'(len) + 1);
    check_eq("r_idle", rsp.r_valid, 0);
    check_eq("r_busy", busy, 0);
    $display("read id=%0d len=%0d beats=%0d err_cnt=%0d", id, len, beats, err_cnt);
  endtask

  // AW and AR accepted together, then B and R-last handshaken in the same cycle.
  task automatic do_dual(input logic [3:0] wid, input logic [3:0] rid);
    req.aw_valid = 1'b1; req.aw.id = wid; req.aw.atop = 6'd0;
    req.ar_valid = 1'b1; req.ar.id = rid; req.ar.len = 8'd0;
    check_eq("dual_aw_ready", rsp.aw_ready, 1);
    check_eq("dual_ar_ready", rsp.ar_ready, 1);
    step();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.w_valid = 1'b1; req.w.last = 1'b1;
    step();
    req.w_valid = 1'b0; req.w.last = 1'b0;
    check_eq("dual_b_valid", rsp.b_valid, 1);
    check_eq("dual_r_valid", rsp.r_valid, 1);
    check_eq("dual_r_last", rsp.r.last, 1);
    check_eq("dual_b_id", rsp.b.id, wid);
    check_eq("dual_r_id", rsp.r.id, rid);
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    step();
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    check_eq("dual_b_off", rsp.b_valid, 0);
    check_eq("dual_r_off", rsp.r_valid, 0);
    $display("dual wid=%0d rid=%0d err_cnt=%0d", wid, rid, err_cnt);
  endtask

  initial begin
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_aw_ready", rsp.aw_ready, 1);
    check_eq("rst_ar_ready", rsp.ar_ready, 1);
    check_eq("rst_w_ready", rsp.w_ready, 0);
    check_eq("rst_b_valid", rsp.b_valid, 0);
    check_eq("rst_r_valid", rsp.r_valid, 0);
    check_eq("rst_r_last", rsp.r.last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_cnt", err_cnt, 0);

    // W before AW is held off.
    req.w_valid = 1'b1;
    check_eq("w_holdoff", rsp.w_ready, 0);
    step();
    req.w_valid = 1'b0;
    check_eq("w_holdoff_idle", busy, 0);

    do_write(4'd1, 4);
    check_eq("cnt_after_write", err_cnt, 1);
    do_read(4'd0, 8'd7, 1'b1);
    check_eq("cnt_after_read7", err_cnt, 2);
    do_read(4'd2, 8'd0, 1'b0);
    check_eq("cnt_after_read0", err_cnt, 3);
    do_read(4'd9, 8'd255, 1'b0);
    check_eq("cnt_after_read255", err_cnt, 4);

    // Atomic write: B, then two R beats carrying the AW id; a new AR waits for the pickup.
    req.aw_valid = 1'b1; req.aw.id = 4'd5; req.aw.len = 8'd1; req.aw.atop = 6'b100000;
    step();
    req.aw_valid = 1'b0; req.aw.atop = 6'd0;
    for (int i = 0; i < 2; i++) begin
      req.w_valid = 1'b1; req.w.last = (i == 1);
      step();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    check_eq("atop_b_valid", rsp.b_valid, 1);
    check_eq("atop_b_id", rsp.b.id, 5);
    req.b_ready = 1'b1;
    step();
    req.b_ready = 1'b0;
    check_eq("atop_busy", busy, 1);
    check_eq("atop_aw_block", rsp.aw_ready, 0);
    step();
    req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd0;
    check_eq("atop_ar_stall", rsp.ar_ready, 0);
    check_eq("atop_r_not_yet", rsp.r_valid, 0);
    step();
    check_eq("atop_r0_valid", rsp.r_valid, 1);
    check_eq("atop_r0_id", rsp.r.id, 5);
    check_eq("atop_r0_last", rsp.r.last, 0);
    check_eq("atop_ar_still", rsp.ar_ready, 0);
    req.r_ready = 1'b1;
    step();
    check_eq("atop_r1_valid", rsp.r_valid, 1);
    check_eq("atop_r1_id", rsp.r.id, 5);
    check_eq("atop_r1_last", rsp.r.last, 1);
    step();
    check_eq("atop_r_done", rsp.r_valid, 0);
    check_eq("atop_ar_ready", rsp.ar_ready, 1);
    step();
    req.ar_valid = 1'b0;
    check_eq("ar_after_r_valid", rsp.r_valid, 1);
    check_eq("ar_after_r_id", rsp.r.id, 3);
    check_eq("ar_after_r_last", rsp.r.last, 1);
    step();
    req.r_ready = 1'b0;
    check_eq("atop_seq_idle", busy, 0);
    check_eq("cnt_after_atop", err_cnt, 7);
    $display("atop id=5 len=1 then ar id=3 err_cnt=%0d", err_cnt);

    do_dual(4'd2, 4'd6);
    check_eq("cnt_dual", err_cnt, 9);

    // 1013 back-to-back single-beat reads (two cycles each) bring the counter to 1022.
    req.ar_valid = 1'b1; req.ar.id = 4'd0; req.ar.len = 8'd0; req.r_ready = 1'b1;
    repeat (2026) step();
    req.ar_valid = 1'b0; req.r_ready = 1'b0;
    check_eq("cnt_1022", err_cnt, 1022);
    check_eq("bulk_idle", busy, 0);
    do_dual(4'd7, 4'd8);
    check_eq("cnt_sat", err_cnt, 1023);
    do_dual(4'd1, 4'd1);
    check_eq("cnt_sat_hold", err_cnt, 1023);

    // Reset in the middle of an R burst.
    req.ar_valid = 1'b1; req.ar.id = 4'd1; req.ar.len = 8'd7;
    step();
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    step();
    step();
    check_eq("mid_r_valid", rsp.r_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; req.r_ready = 1'b0;
    check_eq("mrst_r_valid", rsp.r_valid, 0);
    check_eq("mrst_ar_ready", rsp.ar_ready, 1);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_err_cnt", err_cnt, 0);
    check_eq("mrst_r_last", rsp.r.last, 0);
    $display("reset mid-burst err_cnt=%0d", err_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
